// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
//
// Round-robin arbiter in front of a single-port data memory shared by N_CORES
// matrix-multiplier cores. One core is granted per access. The memory operation
// runs in ACCESS, and RESP either chains directly to the next requester or
// returns to IDLE. The core that was just served is excluded from the RESP
// arbitration because it may still hold its request during that cycle.
//
// Parameters
//   N_CORES  number of core channels (>= 1)
//   DW       data width per core
//   AW       address width; memory holds 2**AW words of DW bits
//
// Ports
//   i_clk         clock, rising edge
//   i_rst         synchronous active-high reset
//   i_req         per-core request, bit n = core n
//   i_we          per-core write enable (1 = write), qualified by i_req
//   i_addr        core n address at [n*AW +: AW]
//   i_wdata       core n write data at [n*DW +: DW]
//   o_ack         one-cycle completion pulse per core
//   o_rdata       core n read data at [n*DW +: DW], holds last value
//   o_contention  saturating count of arbitrations with >= 2 candidates
//
// Optional feature
//   SHARED_MEM_ARB_CONTENTION_EN  when defined, builds the contention counter;
//                                 otherwise o_contention is tied to zero.
// -----------------------------------------------------------------------------
module shared_mem_arbiter #(
  parameter int unsigned N_CORES = 4,
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_CORES-1:0]    i_req,
  input  logic [N_CORES-1:0]    i_we,
  input  logic [N_CORES*AW-1:0] i_addr,
  input  logic [N_CORES*DW-1:0] i_wdata,
  output logic [N_CORES-1:0]    o_ack,
  output logic [N_CORES*DW-1:0] o_rdata,
  output logic [15:0]           o_contention
);

  localparam int unsigned IW    = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int unsigned DEPTH = 32'd1 << AW;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [IW-1:0]        rr_ptr_q;
  logic [IW-1:0]        grant_q;
  logic                 lat_we_q;
  logic [AW-1:0]        lat_addr_q;
  logic [DW-1:0]        lat_wdata_q;

  logic [N_CORES-1:0]   excl_c;
  logic [N_CORES-1:0]   cand_req_c;
  logic                 arb_hit_c;
  logic [IW-1:0]        arb_idx_c;
  logic                 take_c;
  logic [IW-1:0]        next_ptr_c;

  logic [DW-1:0]        mem [DEPTH];

  // Candidate set: in RESP the core just served is masked out.
  always_comb begin
    excl_c = '0;
    if (state_q == RESP) begin
      excl_c = N_CORES'(1) << grant_q;
    end
    cand_req_c = i_req & ~excl_c;
  end

  // Round-robin search starting at rr_ptr, first hit wins.
  always_comb begin
    int unsigned cand;
    arb_hit_c = 1'b0;
    arb_idx_c = '0;
    cand      = 0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      cand = (32'(rr_ptr_q) + k) % N_CORES;
      if (!arb_hit_c && cand_req_c[IW'(cand)]) begin
        arb_hit_c = 1'b1;
        arb_idx_c = IW'(cand);
      end
    end
  end

  // Pointer moves to the core after the one being served.
  always_comb begin
    next_ptr_c = grant_q + IW'(1);
    if (grant_q == IW'(N_CORES - 1)) begin
      next_ptr_c = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and grant-take strobe.
  always_comb begin
    state_d = state_q;
    take_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_hit_c) begin
          take_c  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = RESP;
      end
      RESP: begin
        if (arb_hit_c) begin
          take_c  = 1'b1;
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant latch, ack pulse, read lane update and pointer advance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      o_ack       <= '0;
      o_rdata     <= '0;
    end else begin
      o_ack <= '0;
      if (take_c) begin
        grant_q     <= arb_idx_c;
        lat_we_q    <= i_we[arb_idx_c];
        lat_addr_q  <= i_addr[arb_idx_c*AW +: AW];
        lat_wdata_q <= i_wdata[arb_idx_c*DW +: DW];
      end
      if (state_q == ACCESS) begin
        o_ack[grant_q] <= 1'b1;
        rr_ptr_q       <= next_ptr_c;
        if (!lat_we_q) begin
          o_rdata[grant_q*DW +: DW] <= mem[lat_addr_q];
        end
      end
    end
  end

  // Memory array is not reset; a reset edge suppresses a pending write.
  always_ff @(posedge i_clk) begin
    if (!i_rst && (state_q == ACCESS) && lat_we_q) begin
      mem[lat_addr_q] <= lat_wdata_q;
    end
  end

`ifdef SHARED_MEM_ARB_CONTENTION_EN
  logic        multi_c;
  logic [15:0] contention_q;

  always_comb begin
    multi_c = ($countones(cand_req_c) > 1);
  end

  // Saturating count of grants that had more than one candidate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      contention_q <= '0;
    end else if (take_c && multi_c && (contention_q != 16'hFFFF)) begin
      contention_q <= contention_q + 16'd1;
    end
  end

  assign o_contention = contention_q;
`else
  assign o_contention = '0;
`endif

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_mem_arbiter
//
// Directed bench for shared_mem_arbiter (N_CORES=4, DW=8, AW=16). The sequencer
// pushes the expected ack order into a scoreboard queue before driving the
// cores. A monitor pops one entry per ack and checks the granted core, the
// read lanes and the ack spacing, and checks that outputs are zero after reset.
// -----------------------------------------------------------------------------
module tb_shared_mem_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic            i_clk;
  logic            i_rst;
  logic [N-1:0]    i_req;
  logic [N-1:0]    i_we;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_wdata;
  logic [N-1:0]    o_ack;
  logic [N*DW-1:0] o_rdata;
  logic [15:0]     o_contention;

  logic            req_a   [N];
  logic            we_a    [N];
  logic [AW-1:0]   addr_a  [N];
  logic [DW-1:0]   wd_a    [N];

  typedef struct {
    int            core;
    bit            is_read;
    logic [DW-1:0] rdata;
    int            gap;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

`ifdef SHARED_MEM_ARB_CONTENTION_EN
  localparam logic [15:0] EXP_CONT = 16'd3;
`else
  localparam logic [15:0] EXP_CONT = 16'd0;
`endif

  shared_mem_arbiter #(.N_CORES(N), .DW(DW), .AW(AW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_ack        (o_ack),
    .o_rdata      (o_rdata),
    .o_contention (o_contention)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      i_req[i]              = req_a[i];
      i_we[i]               = we_a[i];
      i_addr[i*AW +: AW]    = addr_a[i];
      i_wdata[i*DW +: DW]   = wd_a[i];
    end
  end

  task automatic push(input int c, input bit rd, input logic [DW-1:0] d, input int gap);
    exp_t e;
    e.core    = c;
    e.is_read = rd;
    e.rdata   = d;
    e.gap     = gap;
    sb_q.push_back(e);
  endtask

  // Drives one transaction on core c, waits for its ack, releases after the ack cycle.
  task automatic core_txn(input int c, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input int exp_lat);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    req_a[c]  = 1'b1;
    we_a[c]   = we;
    addr_a[c] = a;
    wd_a[c]   = d;
    while (!got && n < 40) begin
      @(posedge i_clk);
      n++;
      @(negedge i_clk);
      if (o_ack[c]) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout core=%0d waited=%0d edges", c, n);
    end else if (exp_lat > 0) begin
      checks++;
      if (n != exp_lat) begin
        errors++;
        $display("FAIL ack_latency core=%0d got=%0d want=%0d", c, n, exp_lat);
      end
    end
    @(posedge i_clk);
    #1;
    req_a[c] = 1'b0;
    we_a[c]  = 1'b0;
  endtask

  // Waits (bounded) until every expected ack has been seen.
  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
      sb_q.delete();
    end
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Monitor: reset-state checks, scoreboard pop per ack, lane tracking.
  initial begin
    logic [DW-1:0]   model [N];
    logic [N*DW-1:0] model_v;
    logic [N-1:0]    oh;
    int              cyc;
    int              last_ack;
    bit              rst_e;
    exp_t            e;
    cyc = 0;
    last_ack = 0;
    for (int i = 0; i < N; i++) model[i] = '0;
    forever begin
      @(posedge i_clk);
      rst_e = i_rst;
      cyc++;
      @(negedge i_clk);
      if (rst_e) begin
        for (int i = 0; i < N; i++) model[i] = '0;
        checks++;
        if (o_ack !== '0) begin
          errors++;
          $display("FAIL reset_ack got=%b want=0", o_ack);
        end
        checks++;
        if (o_rdata !== '0) begin
          errors++;
          $display("FAIL reset_rdata got=%h want=0", o_rdata);
        end
        checks++;
        if (o_contention !== 16'h0) begin
          errors++;
          $display("FAIL reset_contention got=%h want=0", o_contention);
        end
      end else begin
        if (o_ack !== '0) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack got=%b want=none", o_ack);
          end else begin
            e = sb_q.pop_front();
            oh = 4'(1) << e.core;
            checks++;
            if (o_ack !== oh) begin
              errors++;
              $display("FAIL ack_order got=%b want=%b", o_ack, oh);
            end
            if (e.is_read) model[e.core] = e.rdata;
            if (e.gap != 0) begin
              checks++;
              if (cyc - last_ack != e.gap) begin
                errors++;
                $display("FAIL ack_spacing core=%0d got=%0d want=%0d", e.core, cyc - last_ack, e.gap);
              end
            end
          end
          last_ack = cyc;
        end
        for (int i = 0; i < N; i++) model_v[i*DW +: DW] = model[i];
        checks++;
        if (o_rdata !== model_v) begin
          errors++;
          $display("FAIL rdata_lanes got=%h want=%h", o_rdata, model_v);
        end
      end
    end
  end

  // Sequencer.
  initial begin
    logic [AW-1:0] pre_addr [N];
    logic [DW-1:0] pre_data [N];
    pre_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    pre_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    checks = 0;
    errors = 0;
    i_rst  = 1'b1;
    for (int i = 0; i < N; i++) begin
      req_a[i]  = 1'b0;
      we_a[i]   = 1'b0;
      addr_a[i] = '0;
      wd_a[i]   = '0;
    end
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Write then read on core 0.
    push(0, 1'b0, 8'h00, 0);
    core_txn(0, 1'b1, 16'h0010, 8'hA5, 2);
    push(0, 1'b1, 8'hA5, 0);
    core_txn(0, 1'b0, 16'h0010, 8'h00, 2);
    drain();
    checks++;
    if (o_rdata !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL write_read_lanes got=%h want=000000a5", o_rdata);
    end

    // Preload, then all four cores read at once after reset.
    for (int i = 0; i < N; i++) begin
      push(0, 1'b0, 8'h00, 0);
      core_txn(0, 1'b1, pre_addr[i], pre_data[i], 2);
    end
    drain();
    do_reset();
    push(0, 1'b1, 8'h11, 0);
    push(1, 1'b1, 8'h22, 2);
    push(2, 1'b1, 8'h33, 2);
    push(3, 1'b1, 8'h44, 2);
    fork
      core_txn(0, 1'b0, 16'h0100, 8'h00, 2);
      core_txn(1, 1'b0, 16'h0101, 8'h00, 0);
      core_txn(2, 1'b0, 16'h0102, 8'h00, 0);
      core_txn(3, 1'b0, 16'h0103, 8'h00, 0);
    join
    drain();
    checks++;
    if (o_contention !== EXP_CONT) begin
      errors++;
      $display("FAIL contention_count got=%0d want=%0d", o_contention, EXP_CONT);
    end
    checks++;
    if (o_rdata !== 32'h4433_2211) begin
      errors++;
      $display("FAIL contention_lanes got=%h want=44332211", o_rdata);
    end

    // Fairness: cores 1 and 2 re-request back to back.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      push(1, 1'b1, 8'h22, (k == 0) ? 0 : 2);
      push(2, 1'b1, 8'h33, 2);
    end
    fork
      begin
        for (int k = 0; k < 4; k++) core_txn(1, 1'b0, 16'h0101, 8'h00, 0);
      end
      begin
        for (int k = 0; k < 4; k++) core_txn(2, 1'b0, 16'h0102, 8'h00, 0);
      end
    join
    drain();

    // Reset during ACCESS drops core 3's write.
    do_reset();
    push(3, 1'b0, 8'h00, 0);
    core_txn(3, 1'b1, 16'h0020, 8'h00, 2);
    drain();
    req_a[3]  = 1'b1;
    we_a[3]   = 1'b1;
    addr_a[3] = 16'h0020;
    wd_a[3]   = 8'h3C;
    @(posedge i_clk);
    #1;
    i_rst    = 1'b1;
    req_a[3] = 1'b0;
    we_a[3]  = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if ({o_ack, o_rdata, o_contention} !== '0) begin
      errors++;
      $display("FAIL post_reset_outputs ack=%b rdata=%h cont=%h want=all zero",
               o_ack, o_rdata, o_contention);
    end
    repeat (3) @(posedge i_clk);
    #1;
    push(3, 1'b1, 8'h00, 0);
    core_txn(3, 1'b0, 16'h0020, 8'h00, 2);
    drain();

    // Wrap-around: after serving core 2, core 3 wins over core 0.
    do_reset();
    push(2, 1'b1, 8'h33, 0);
    core_txn(2, 1'b0, 16'h0102, 8'h00, 2);
    push(3, 1'b1, 8'h44, 0);
    push(0, 1'b1, 8'h11, 2);
    fork
      core_txn(0, 1'b0, 16'h0100, 8'h00, 0);
      core_txn(3, 1'b0, 16'h0103, 8'h00, 2);
    join
    drain();

`ifdef SHARED_MEM_ARB_CONTENTION_EN
    // Counter saturation from a deposited near-full value.
    do_reset();
    dut.contention_q = 16'hFFFE;
    push(0, 1'b1, 8'h11, 0);
    push(1, 1'b1, 8'h22, 2);
    push(2, 1'b1, 8'h33, 2);
    push(3, 1'b1, 8'h44, 2);
    fork
      core_txn(0, 1'b0, 16'h0100, 8'h00, 2);
      core_txn(1, 1'b0, 16'h0101, 8'h00, 0);
      core_txn(2, 1'b0, 16'h0102, 8'h00, 0);
      core_txn(3, 1'b0, 16'h0103, 8'h00, 0);
    join
    drain();
    checks++;
    if (o_contention !== 16'hFFFF) begin
      errors++;
      $display("FAIL contention_saturate got=%h want=ffff", o_contention);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/shared_mem_arbiter.md
# shared_mem_arbiter

Parametrised round-robin arbiter in front of a single-port on-chip data memory shared by `N_CORES` matrix-multiplier cores. Each core owns a request/acknowledge channel carrying address, write enable and write data. The block grants one core per access, performs the memory operation and returns per-core read data with an acknowledge pulse. It replaces the fixed four-core, fixed-sequence memory control unit with request-driven fair arbitration.

## Interface
- `N_CORES`, 4: number of core channels (≥1).
- `DW`, 8: data width per core.
- `AW`, 16: address width; memory depth is 2**AW words of DW bits.
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_rst` in 1: synchronous active-high reset.
- `i_req` in N_CORES: per-core request; bit n belongs to core n.
- `i_we` in N_CORES: per-core write enable (1 = write, 0 = read), qualified by `i_req`.
- `i_addr` in N_CORES*AW: core n address at `[n*AW +: AW]`.
- `i_wdata` in N_CORES*DW: core n write data at `[n*DW +: DW]`.
- `o_ack` out N_CORES: one-cycle completion pulse per core.
- `o_rdata` out N_CORES*DW: core n read data at `[n*DW +: DW]`; holds its last value.
- `o_contention` out 16: contention counter (see Configuration).

## Operation
- States: IDLE, ACCESS, RESP.
- Round-robin pointer `rr_ptr` (0..N_CORES-1). Arbitration picks the first requesting core at index `rr_ptr`, `rr_ptr+1`, … modulo N_CORES.
- IDLE: if any `i_req`, arbitrate. Latch grant index g, plus g's address, write enable and write data. Go to ACCESS. Otherwise stay in IDLE.
- ACCESS: a write stores the latched data at the latched address. A read loads `mem[addr]` into lane g of `o_rdata`. Either way set `o_ack[g]`=1, set `rr_ptr`=(g+1) mod N_CORES, and go to RESP.
- RESP: clear `o_ack`. Arbitrate among requests excluding core g. On a hit, latch the new grant and go to ACCESS; otherwise go to IDLE.
- Handshake: a core holds `i_req`, `i_we`, `i_addr` and `i_wdata` stable until it sees `o_ack`. It deasserts `i_req` or presents a new request on the edge after the ack cycle. Each access is served exactly once.
- Writes never change `o_rdata`. Lanes of non-granted cores never change.
- Memory contents are not reset. Reads of never-written addresses return undefined data.
- Reset value of every output: `o_ack`=0, `o_rdata`=0, `o_contention`=0. Reset also sets the state to IDLE and `rr_ptr`=0.
- Reset mid-operation: the reset edge wins. A pending write in ACCESS is suppressed, no ack is issued, and the transaction is dropped. The core must re-request.
- Arbitration count covers every grant taken in IDLE or RESP.

## Timing
- Isolated request sampled at IDLE edge E0: memory operation at edge E1. `o_ack[g]` and read data are valid in the cycle after E1, and the ack clears at E2.
- Request-to-ack latency is 2 edges.
- With multiple cores requesting, acks are spaced 2 cycles apart (ACCESS/RESP alternation).
- The same core is never granted on consecutive arbitrations while another core is requesting.
- A core that keeps `i_req` high after its ack is re-arbitrated only after another core's grant or after a pass through IDLE.
- With N_CORES=1, the RESP exclusion always misses, so every transaction is IDLE→ACCESS→RESP (3 cycles).

## Configuration
- `SHARED_MEM_ARB_CONTENTION_EN` defined:
  - `o_contention` increments by 1 at each arbitration where two or more bits of `i_req` (after the RESP exclusion) are set.
  - The counter saturates at 16'hFFFF and clears on reset.
- Undefined: the counter logic is not built and `o_contention` is constant 0.

## Test plan
- Write then read: after reset, core 0 writes 8'hA5 to 16'h0010, then reads 16'h0010. Expect two single acks 2 edges after each request, `o_rdata` lane 0 = 8'hA5, and lanes 1–3 = 0.
- Full contention: all 4 cores read distinct preloaded addresses in the same cycle after reset. Expect ack order 0,1,2,3, acks 2 cycles apart, each lane holding its own word, and `o_contention`=3 when the macro is defined (0 when undefined).
- Fairness: cores 1 and 2 hold `i_req` continuously, re-requesting immediately after each ack, for 8 transactions. Expect grants to alternate 1,2,1,2… and core 1 never granted twice in a row.
- Reset mid-access: core 3 writes 8'h3C to 16'h0020 and `i_rst` is asserted on the ACCESS edge. Expect no `o_ack`, a later read of 16'h0020 not returning 8'h3C (address pre-written with 8'h00 returns 8'h00), and all outputs zero after reset.
- Wrap-around: `rr_ptr`=3 after serving core 2; cores 0 and 3 request. Expect core 3 first, then core 0.
- Counter saturation (macro defined): force `o_contention` to 16'hFFFE via hierarchical deposit, then run 3 contended arbitrations. Expect the counter to stick at 16'hFFFF.
